// File: rtl/exu_div_wb.sv
// exu_div_wb: writeback stage behind the EXU divider.
// Holds the destination tag of the single in-flight divide, captures the
// divider result one cycle after finish, and presents it on the shared
// valid/ready writeback port until it is accepted.
module exu_div_wb #(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             div_issue_valid,
    input  logic [TAG_W-1:0] div_issue_rd,
    output logic             div_issue_ready,
    input  logic             flush_lower,
    input  logic             div_finish,
    input  logic             div_finish_early,
    input  logic [31:0]      div_out,
    output logic             wb_valid,
    output logic [TAG_W-1:0] wb_rd,
    output logic [31:0]      wb_data,
    input  logic             wb_ready,
    output logic             div_busy,
    output logic [5:0]       div_lat,
    output logic             div_early_ff
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        CAPT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t           state_q;
    logic [TAG_W-1:0] tag_q;
    logic [5:0]       cnt_q;
    logic [5:0]       cnt_d;
    logic             early_q;
    logic             issue_ready_q;
    logic             busy_q;
    logic             wb_valid_q;
    logic [TAG_W-1:0] wb_rd_q;
    logic [31:0]      wb_data_q;
    logic [5:0]       div_lat_q;
    logic             div_early_ff_q;

    // Unsigned 6-bit increment that sticks at the all-ones value.
    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        if (v == 6'd63) begin
            return v;
        end
        return v + 6'd1;
    endfunction

    // Busy-cycle count including the current cycle.
    assign cnt_d = sat_inc6(cnt_q);

    // Divide tracking FSM with registered outputs. The divider result is only
    // valid in the cycle after finish, hence the one-cycle CAPT state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            tag_q          <= '0;
            cnt_q          <= '0;
            early_q        <= 1'b0;
            issue_ready_q  <= 1'b1;
            busy_q         <= 1'b0;
            wb_valid_q     <= 1'b0;
            wb_rd_q        <= '0;
            wb_data_q      <= '0;
            div_lat_q      <= '0;
            div_early_ff_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A divide issued in a flush cycle is dropped.
                    if (div_issue_valid && !flush_lower) begin
                        tag_q         <= div_issue_rd;
                        cnt_q         <= '0;
                        state_q       <= BUSY;
                        issue_ready_q <= 1'b0;
                        busy_q        <= 1'b1;
                    end
                end
                BUSY: begin
                    cnt_q <= cnt_d;
                    // Flush takes priority over a coincident finish.
                    if (flush_lower) begin
                        state_q       <= IDLE;
                        issue_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end else if (div_finish) begin
                        early_q <= div_finish_early;
                        state_q <= CAPT;
                    end
                end
                CAPT: begin
                    // Divide has completed; flush no longer applies.
                    wb_data_q      <= div_out;
                    wb_rd_q        <= tag_q;
                    div_lat_q      <= cnt_q;
                    div_early_ff_q <= early_q;
                    wb_valid_q     <= 1'b1;
                    state_q        <= HOLD;
                end
                HOLD: begin
                    if (wb_ready) begin
                        wb_valid_q    <= 1'b0;
                        state_q       <= IDLE;
                        issue_ready_q <= 1'b1;
                        busy_q        <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    wb_valid_q    <= 1'b0;
                    issue_ready_q <= 1'b1;
                    busy_q        <= 1'b0;
                end
            endcase
        end
    end

    assign div_issue_ready = issue_ready_q;
    assign div_busy        = busy_q;
    assign wb_valid        = wb_valid_q;
    assign wb_rd           = wb_rd_q;
    assign wb_data         = wb_data_q;
    assign div_lat         = div_lat_q;
    assign div_early_ff    = div_early_ff_q;

endmodule

// File: tb/tb_exu_div_wb.sv
// Directed testbench for exu_div_wb. Inputs are driven and outputs sampled
// 1 time unit after each rising clock edge.
module tb_exu_div_wb;

    logic        clk;
    logic        rst;
    logic        div_issue_valid;
    logic [4:0]  div_issue_rd;
    logic        div_issue_ready;
    logic        flush_lower;
    logic        div_finish;
    logic        div_finish_early;
    logic [31:0] div_out;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_ready;
    logic        div_busy;
    logic [5:0]  div_lat;
    logic        div_early_ff;

    int vec_cnt;
    int err_cnt;

    exu_div_wb #(.TAG_W(5)) dut (
        .clk              (clk),
        .rst              (rst),
        .div_issue_valid  (div_issue_valid),
        .div_issue_rd     (div_issue_rd),
        .div_issue_ready  (div_issue_ready),
        .flush_lower      (flush_lower),
        .div_finish       (div_finish),
        .div_finish_early (div_finish_early),
        .div_out          (div_out),
        .wb_valid         (wb_valid),
        .wb_rd            (wb_rd),
        .wb_data          (wb_data),
        .wb_ready         (wb_ready),
        .div_busy         (div_busy),
        .div_lat          (div_lat),
        .div_early_ff     (div_early_ff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        div_issue_valid = 1'b0; div_issue_rd = '0; flush_lower = 1'b0;
        div_finish = 1'b0; div_finish_early = 1'b0; div_out = 32'h0; wb_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        tick();
        vec_cnt++; if (wb_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_wb_valid got=%0b exp=0", wb_valid); end
        vec_cnt++; if (div_issue_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_ready got=%0b exp=1", div_issue_ready); end
        vec_cnt++; if (div_busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy got=%0b exp=0", div_busy); end
        vec_cnt++; if (wb_rd !== 5'd0 || wb_data !== 32'h0) begin err_cnt++; $display("FAIL reset_rd_data got=%0d/%h exp=0/0", wb_rd, wb_data); end
        vec_cnt++; if (div_lat !== 6'd0 || div_early_ff !== 1'b0) begin err_cnt++; $display("FAIL reset_lat_early got=%0d/%0b exp=0/0", div_lat, div_early_ff); end
    endtask

    task automatic test_smallnum();
        // t0: issue rd=7
        vec_cnt++; if (div_issue_ready !== 1'b1) begin err_cnt++; $display("FAIL small_ready_t0 got=%0b exp=1", div_issue_ready); end
        div_issue_valid = 1'b1; div_issue_rd = 5'd7;
        tick();
        // t1: first BUSY cycle, smallnum finish
        div_issue_valid = 1'b0;
        div_finish = 1'b1; div_finish_early = 1'b1; div_out = 32'hAAAA_5555;
        vec_cnt++; if (div_busy !== 1'b1 || div_issue_ready !== 1'b0) begin err_cnt++; $display("FAIL small_busy_t1 got busy=%0b ready=%0b exp=1/0", div_busy, div_issue_ready); end
        tick();
        // t2: CAPT, result valid on div_out
        div_finish = 1'b0; div_finish_early = 1'b0; div_out = 32'h0000_0003;
        vec_cnt++; if (wb_valid !== 1'b0) begin err_cnt++; $display("FAIL small_wbv_t2 got=%0b exp=0", wb_valid); end
        tick();
        // t3: HOLD, accepted this cycle
        div_out = 32'h1234_5678; wb_ready = 1'b1;
        vec_cnt++; if (wb_valid !== 1'b1) begin err_cnt++; $display("FAIL small_wbv_t3 got=%0b exp=1", wb_valid); end
        vec_cnt++; if (wb_rd !== 5'd7 || wb_data !== 32'h0000_0003) begin err_cnt++; $display("FAIL small_rd_data got=%0d/%h exp=7/00000003", wb_rd, wb_data); end
        vec_cnt++; if (div_lat !== 6'd1 || div_early_ff !== 1'b1) begin err_cnt++; $display("FAIL small_lat_early got=%0d/%0b exp=1/1", div_lat, div_early_ff); end
        tick();
        // t4: back in IDLE
        wb_ready = 1'b0;
        vec_cnt++; if (wb_valid !== 1'b0 || div_issue_ready !== 1'b1 || div_busy !== 1'b0) begin err_cnt++; $display("FAIL small_idle_t4 got v=%0b r=%0b b=%0b exp=0/1/0", wb_valid, div_issue_ready, div_busy); end
    endtask

    task automatic test_full_divide();
        int vcount;
        vcount = 0;
        div_issue_valid = 1'b1; div_issue_rd = 5'd12;
        tick();
        div_issue_valid = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            div_finish = (i == 33);
            div_out = 32'h0F0F_0000 + i;
            if (wb_valid) vcount++;
            tick();
        end
        div_finish = 1'b0; div_out = 32'hFFFF_FFF9;
        if (wb_valid) vcount++;
        tick();
        // HOLD with wb_ready low for 4 cycles
        for (int i = 0; i < 4; i++) begin
            div_out = 32'h5A5A_0000 + i;
            if (wb_valid) vcount++;
            vec_cnt++; if (wb_rd !== 5'd12 || wb_data !== 32'hFFFF_FFF9) begin err_cnt++; $display("FAIL full_hold_stable[%0d] got=%0d/%h exp=12/fffffff9", i, wb_rd, wb_data); end
            tick();
        end
        wb_ready = 1'b1;
        if (wb_valid) vcount++;
        vec_cnt++; if (div_lat !== 6'd33 || div_early_ff !== 1'b0) begin err_cnt++; $display("FAIL full_lat_early got=%0d/%0b exp=33/0", div_lat, div_early_ff); end
        tick();
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (wb_valid) vcount++;
            tick();
        end
        vec_cnt++; if (vcount != 5) begin err_cnt++; $display("FAIL full_valid_cycles got=%0d exp=5", vcount); end
        vec_cnt++; if (div_issue_ready !== 1'b1) begin err_cnt++; $display("FAIL full_idle got=%0b exp=1", div_issue_ready); end
    endtask

    task automatic test_flush();
        int vcount;
        vcount = 0;
        div_issue_valid = 1'b1; div_issue_rd = 5'd3;
        tick();
        div_issue_valid = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            flush_lower = (i == 10);
            tick();
        end
        flush_lower = 1'b0;
        vec_cnt++; if (div_issue_ready !== 1'b1 || div_busy !== 1'b0) begin err_cnt++; $display("FAIL flush_idle got r=%0b b=%0b exp=1/0", div_issue_ready, div_busy); end
        // stray finish outside BUSY must be ignored
        for (int i = 0; i < 4; i++) begin
            div_finish = 1'b1; div_out = 32'hBAD0_0000 + i;
            if (wb_valid) vcount++;
            tick();
        end
        div_finish = 1'b0;
        vec_cnt++; if (vcount != 0 || wb_valid !== 1'b0) begin err_cnt++; $display("FAIL flush_no_wb got=%0d exp=0", vcount); end
        div_issue_valid = 1'b1; div_issue_rd = 5'd4;
        tick();
        div_issue_valid = 1'b0; div_finish = 1'b1;
        tick();
        div_finish = 1'b0; div_out = 32'h0000_0044;
        tick();
        wb_ready = 1'b1;
        vec_cnt++; if (wb_valid !== 1'b1 || wb_rd !== 5'd4 || wb_data !== 32'h44) begin err_cnt++; $display("FAIL flush_next_wb got v=%0b rd=%0d d=%h exp=1/4/00000044", wb_valid, wb_rd, wb_data); end
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_simultaneous();
        int vcount;
        vcount = 0;
        div_issue_valid = 1'b1; div_issue_rd = 5'd9; flush_lower = 1'b1;
        tick();
        div_issue_valid = 1'b0; flush_lower = 1'b0;
        vec_cnt++; if (div_busy !== 1'b0 || div_issue_ready !== 1'b1) begin err_cnt++; $display("FAIL simul_issue_flush got b=%0b r=%0b exp=0/1", div_busy, div_issue_ready); end
        div_issue_valid = 1'b1; div_issue_rd = 5'd10;
        tick();
        div_issue_valid = 1'b0; div_finish = 1'b1; flush_lower = 1'b1;
        tick();
        div_finish = 1'b0; flush_lower = 1'b0; div_out = 32'hCAFE_F00D;
        vec_cnt++; if (div_busy !== 1'b0 || div_issue_ready !== 1'b1) begin err_cnt++; $display("FAIL simul_finish_flush got b=%0b r=%0b exp=0/1", div_busy, div_issue_ready); end
        for (int i = 0; i < 4; i++) begin
            if (wb_valid) vcount++;
            tick();
        end
        vec_cnt++; if (vcount != 0 || wb_rd !== 5'd4) begin err_cnt++; $display("FAIL simul_no_wb got cnt=%0d rd=%0d exp=0/4", vcount, wb_rd); end
    endtask

    task automatic test_back_to_back();
        div_issue_valid = 1'b1; div_issue_rd = 5'd20;
        tick();
        // BUSY cycle 1: illegal issue attempt, must not overwrite tag
        div_issue_rd = 5'd21;
        vec_cnt++; if (div_issue_ready !== 1'b0) begin err_cnt++; $display("FAIL b2b_busy_ready got=%0b exp=0", div_issue_ready); end
        tick();
        div_issue_valid = 1'b0; div_finish = 1'b1;
        tick();
        div_finish = 1'b0; div_out = 32'h0000_1234;
        tick();
        // HOLD: issue attempt ignored
        div_issue_valid = 1'b1; div_issue_rd = 5'd23;
        vec_cnt++; if (div_issue_ready !== 1'b0 || wb_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_hold_ready got r=%0b v=%0b exp=0/1", div_issue_ready, wb_valid); end
        tick();
        div_issue_valid = 1'b0;
        vec_cnt++; if (wb_valid !== 1'b1 || wb_rd !== 5'd20 || wb_data !== 32'h1234 || div_lat !== 6'd2) begin err_cnt++; $display("FAIL b2b_first_wb got v=%0b rd=%0d d=%h lat=%0d exp=1/20/00001234/2", wb_valid, wb_rd, wb_data, div_lat); end
        wb_ready = 1'b1;
        tick();
        // k+1: new issue accepted
        wb_ready = 1'b0;
        vec_cnt++; if (div_issue_ready !== 1'b1 || wb_valid !== 1'b0) begin err_cnt++; $display("FAIL b2b_ready_k1 got r=%0b v=%0b exp=1/0", div_issue_ready, wb_valid); end
        div_issue_valid = 1'b1; div_issue_rd = 5'd22;
        tick();
        div_issue_valid = 1'b0; div_finish = 1'b1; div_finish_early = 1'b1;
        tick();
        div_finish = 1'b0; div_finish_early = 1'b0; div_out = 32'h0000_5678;
        tick();
        wb_ready = 1'b1;
        vec_cnt++; if (wb_valid !== 1'b1 || wb_rd !== 5'd22 || wb_data !== 32'h5678 || div_lat !== 6'd1 || div_early_ff !== 1'b1) begin err_cnt++; $display("FAIL b2b_second_wb got v=%0b rd=%0d d=%h lat=%0d e=%0b exp=1/22/00005678/1/1", wb_valid, wb_rd, wb_data, div_lat, div_early_ff); end
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_saturation();
        div_issue_valid = 1'b1; div_issue_rd = 5'd30;
        tick();
        div_issue_valid = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            div_finish = (i == 70);
            tick();
        end
        div_finish = 1'b0; div_out = 32'h0000_0063;
        tick();
        wb_ready = 1'b1;
        vec_cnt++; if (wb_valid !== 1'b1 || div_lat !== 6'd63 || wb_rd !== 5'd30) begin err_cnt++; $display("FAIL sat_lat got v=%0b lat=%0d rd=%0d exp=1/63/30", wb_valid, div_lat, wb_rd); end
        tick();
        wb_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        div_issue_valid = 1'b1; div_issue_rd = 5'd5;
        tick();
        div_issue_valid = 1'b0;
        tick(); tick();
        div_finish = 1'b1;
        tick();
        div_finish = 1'b0; div_out = 32'hDEAD_BEEF;
        tick();
        vec_cnt++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEAD_BEEF || div_lat !== 6'd3) begin err_cnt++; $display("FAIL rstmid_hold got v=%0b d=%h lat=%0d exp=1/deadbeef/3", wb_valid, wb_data, div_lat); end
        // asynchronous reset between clock edges
        #2 rst = 1'b1;
        #1;
        vec_cnt++; if (wb_valid !== 1'b0 || wb_data !== 32'h0 || div_lat !== 6'd0 || wb_rd !== 5'd0) begin err_cnt++; $display("FAIL rstmid_async got v=%0b d=%h lat=%0d rd=%0d exp=0/0/0/0", wb_valid, wb_data, div_lat, wb_rd); end
        vec_cnt++; if (div_issue_ready !== 1'b1 || div_busy !== 1'b0) begin err_cnt++; $display("FAIL rstmid_ready got r=%0b b=%0b exp=1/0", div_issue_ready, div_busy); end
        tick();
        rst = 1'b0;
        wb_ready = 1'b1;
        tick(); tick();
        vec_cnt++; if (wb_valid !== 1'b0 || div_busy !== 1'b0 || div_issue_ready !== 1'b1) begin err_cnt++; $display("FAIL rstmid_after got v=%0b b=%0b r=%0b exp=0/0/1", wb_valid, div_busy, div_issue_ready); end
        wb_ready = 1'b0;
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_smallnum();
        test_full_divide();
        test_flush();
        test_simultaneous();
        test_back_to_back();
        test_saturation();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
